// File: rtl/tm1638_scan_ctrl.sv
// TM1638 display refresh controller: sends command, digit/LED data and brightness frames on stb/TM_clk/DIO.
// Define TM1638_KEYSCAN_EN to append a key-read frame that returns the 32-bit key matrix on keys/keys_valid.
module tm1638_scan_ctrl #(
    parameter int NUM_DIGITS = 8,
    parameter int CLK_DIV    = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [8*NUM_DIGITS-1:0] seg_data,
    input  logic [NUM_DIGITS-1:0]   led,
    input  logic [2:0]              bright,
    input  logic                    disp_on,
    input  logic                    update,
    output logic                    busy,
    output logic                    done,
    output logic                    stb,
    output logic                    TM_clk,
    output logic                    dio_o,
    output logic                    dio_oe,
    input  logic                    dio_i
`ifdef TM1638_KEYSCAN_EN
    ,
    output logic [31:0]             keys,
    output logic                    keys_valid
`endif
);

    localparam int             CW      = $clog2(2 * CLK_DIV);
    localparam logic [CW-1:0]  CNT_ONE = CW'(1);
    localparam logic [CW-1:0]  CD_M1   = CW'(CLK_DIV - 1);
    localparam logic [CW-1:0]  GAP_M1  = CW'(2 * CLK_DIV - 1);
    localparam logic [4:0]     F2_LAST = 5'(2 * NUM_DIGITS);
`ifdef TM1638_KEYSCAN_EN
    localparam logic [1:0]     LAST_FRAME = 2'd3;
`else
    localparam logic [1:0]     LAST_FRAME = 2'd2;
`endif

    typedef enum logic [2:0] {
        IDLE,
        STB_LO,
        SHIFT,
        STB_HI,
        GAP
`ifdef TM1638_KEYSCAN_EN
        ,
        KEY_WAIT,
        KEY_RD
`endif
    } state_t;

    state_t                  state_q, state_d;
    logic [CW-1:0]           cnt_q, cnt_d;
    logic                    half_q, half_d;
    logic [4:0]              bit_q, bit_d;
    logic [4:0]              byte_q, byte_d;
    logic [1:0]              frame_q, frame_d;
    logic                    dio_q, dio_d;
    logic                    done_q, done_d;
    logic                    pend_q, pend_d;
    logic [8*NUM_DIGITS-1:0] seg_lat_q, seg_lat_d;
    logic [NUM_DIGITS-1:0]   led_lat_q, led_lat_d;
    logic [2:0]              bright_lat_q, bright_lat_d;
    logic                    disp_lat_q, disp_lat_d;
`ifdef TM1638_KEYSCAN_EN
    logic [31:0]             key_sr_q, key_sr_d;
    logic [31:0]             keys_q, keys_d;
    logic                    keys_valid_q, keys_valid_d;
`else
    logic                    unused_dio_i;
    assign unused_dio_i = dio_i;
`endif

    logic [7:0] cur_byte;
    logic [7:0] nxt_byte;
    logic [4:0] bit_nxt;
    logic [4:0] last_byte;
    logic       phase_end;
    logic       gap_end;

    // Byte idx of frame fr; F2 interleaves segment byte and LED byte per digit after the address byte.
    function automatic logic [7:0] frame_byte(input logic [1:0] fr, input logic [4:0] idx);
        logic [4:0] j;
        logic [7:0] b;
        j = idx - 5'd1;
        b = 8'h00;
        case (fr)
            2'd0: b = 8'h40;
            2'd1: begin
                if (idx == 5'd0) begin
                    b = 8'hC0;
                end else begin
                    for (int k = 0; k < NUM_DIGITS; k++) begin
                        if (j[4:1] == 4'(k)) begin
                            b = j[0] ? {7'b0, led_lat_q[k]} : seg_lat_q[8*k +: 8];
                        end
                    end
                end
            end
            2'd2:    b = {4'b1000, disp_lat_q, bright_lat_q};
            default: b = 8'h42;
        endcase
        return b;
    endfunction

    assign cur_byte  = frame_byte(frame_q, byte_q);
    assign nxt_byte  = frame_byte(frame_q, byte_q + 5'd1);
    assign bit_nxt   = bit_q + 5'd1;
    assign last_byte = (frame_q == 2'd1) ? F2_LAST : 5'd0;
    assign phase_end = (cnt_q == CD_M1);
    assign gap_end   = (cnt_q == GAP_M1);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            half_q       <= 1'b0;
            bit_q        <= '0;
            byte_q       <= '0;
            frame_q      <= '0;
            dio_q        <= 1'b1;
            done_q       <= 1'b0;
            pend_q       <= 1'b0;
`ifdef TM1638_KEYSCAN_EN
            keys_q       <= '0;
            keys_valid_q <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            half_q       <= half_d;
            bit_q        <= bit_d;
            byte_q       <= byte_d;
            frame_q      <= frame_d;
            dio_q        <= dio_d;
            done_q       <= done_d;
            pend_q       <= pend_d;
`ifdef TM1638_KEYSCAN_EN
            keys_q       <= keys_d;
            keys_valid_q <= keys_valid_d;
`endif
        end
    end

    // Latched frame data and the key shift register carry no reset; they are always written before use.
    always_ff @(posedge clk) begin
        seg_lat_q    <= seg_lat_d;
        led_lat_q    <= led_lat_d;
        bright_lat_q <= bright_lat_d;
        disp_lat_q   <= disp_lat_d;
`ifdef TM1638_KEYSCAN_EN
        key_sr_q     <= key_sr_d;
`endif
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        half_d       = half_q;
        bit_d        = bit_q;
        byte_d       = byte_q;
        frame_d      = frame_q;
        dio_d        = dio_q;
        done_d       = 1'b0;
        pend_d       = pend_q;
        seg_lat_d    = seg_lat_q;
        led_lat_d    = led_lat_q;
        bright_lat_d = bright_lat_q;
        disp_lat_d   = disp_lat_q;
`ifdef TM1638_KEYSCAN_EN
        key_sr_d     = key_sr_q;
        keys_d       = keys_q;
        keys_valid_d = 1'b0;
`endif
        if (update && state_q != IDLE) begin
            pend_d = 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (update || pend_q) begin
                    state_d      = STB_LO;
                    cnt_d        = '0;
                    frame_d      = '0;
                    byte_d       = '0;
                    pend_d       = 1'b0;
                    seg_lat_d    = seg_data;
                    led_lat_d    = led;
                    bright_lat_d = bright;
                    disp_lat_d   = disp_on;
                end
            end
            STB_LO: begin
                if (phase_end) begin
                    state_d = SHIFT;
                    cnt_d   = '0;
                    half_d  = 1'b0;
                    bit_d   = '0;
                    dio_d   = cur_byte[0];
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            SHIFT: begin
                if (!phase_end) begin
                    cnt_d = cnt_q + CNT_ONE;
                end else if (!half_q) begin
                    cnt_d  = '0;
                    half_d = 1'b1;
                end else if (bit_q != 5'd7) begin
                    cnt_d  = '0;
                    half_d = 1'b0;
                    bit_d  = bit_nxt;
                    dio_d  = cur_byte[bit_nxt[2:0]];
                end else if (byte_q != last_byte) begin
                    cnt_d  = '0;
                    half_d = 1'b0;
                    bit_d  = '0;
                    byte_d = byte_q + 5'd1;
                    dio_d  = nxt_byte[0];
                end else begin
                    cnt_d   = '0;
`ifdef TM1638_KEYSCAN_EN
                    state_d = (frame_q == 2'd3) ? KEY_WAIT : STB_HI;
`else
                    state_d = STB_HI;
`endif
                end
            end
            STB_HI: begin
                if (phase_end) begin
                    state_d = GAP;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            GAP: begin
                if (!gap_end) begin
                    cnt_d = cnt_q + CNT_ONE;
                end else if (frame_q == LAST_FRAME) begin
                    state_d      = IDLE;
                    cnt_d        = '0;
                    done_d       = 1'b1;
`ifdef TM1638_KEYSCAN_EN
                    keys_d       = key_sr_q;
                    keys_valid_d = 1'b1;
`endif
                end else begin
                    state_d = STB_LO;
                    cnt_d   = '0;
                    byte_d  = '0;
                    frame_d = frame_q + 2'd1;
                end
            end
`ifdef TM1638_KEYSCAN_EN
            // Turnaround: DIO released while the TM1638 prepares its first key bit.
            KEY_WAIT: begin
                if (gap_end) begin
                    state_d = KEY_RD;
                    cnt_d   = '0;
                    half_d  = 1'b0;
                    bit_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            KEY_RD: begin
                if (!phase_end) begin
                    cnt_d = cnt_q + CNT_ONE;
                end else if (!half_q) begin
                    cnt_d           = '0;
                    half_d          = 1'b1;
                    key_sr_d[bit_q] = dio_i;
                end else if (bit_q == 5'd31) begin
                    state_d = STB_HI;
                    cnt_d   = '0;
                end else begin
                    cnt_d  = '0;
                    half_d = 1'b0;
                    bit_d  = bit_nxt;
                end
            end
`endif
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        stb    = 1'b1;
        TM_clk = 1'b1;
        dio_oe = 1'b1;
        case (state_q)
            STB_LO, STB_HI: stb = 1'b0;
            SHIFT: begin
                stb    = 1'b0;
                TM_clk = half_q;
            end
`ifdef TM1638_KEYSCAN_EN
            KEY_WAIT: begin
                stb    = 1'b0;
                dio_oe = 1'b0;
            end
            KEY_RD: begin
                stb    = 1'b0;
                TM_clk = half_q;
                dio_oe = 1'b0;
            end
`endif
            default: ;
        endcase
    end

    assign busy  = (state_q != IDLE);
    assign done  = done_q;
    assign dio_o = dio_q;
`ifdef TM1638_KEYSCAN_EN
    assign keys       = keys_q;
    assign keys_valid = keys_valid_q;
`endif

endmodule
